// File: rtl/xbar_pkg.sv
// Shared definitions for the 4x4 crossbar input requester and output arbiters.
// Holds port/answer widths, the requester state encoding and the grant decode.
package xbar_pkg;

  localparam int NPORTS = 4;
  localparam int PORT_W = 2;
  localparam int ANS_W  = 3;
  localparam logic [ANS_W-1:0] ANS_IDLE = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_XFER = 3'd2,
    ST_REL  = 3'd3,
    ST_DROP = 3'd4
  } state_t;

  // An output grants us when its ArbR is set and its answer names our port.
  function automatic logic is_grant(
    input logic [NPORTS-1:0]       arb_r,
    input logic [NPORTS*ANS_W-1:0] answer,
    input logic [PORT_W-1:0]       dest,
    input logic [PORT_W-1:0]       port
  );
    logic [ANS_W-1:0] field;
    field = answer[ANS_W*int'(dest) +: ANS_W];
    return arb_r[dest] && (field == {1'b0, port});
  endfunction

endpackage

// File: rtl/xbar_in_requester.sv
// Input-side requester: decodes the header destination, requests an output,
// streams the packet once granted and pulses release, or drops on timeout.
module xbar_in_requester
  import xbar_pkg::*;
#(
  parameter int PORT_ID = 0,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    src_valid,
  input  logic [DATA_W-1:0]       src_data,
  input  logic                    src_last,
  output logic                    src_ready,
  output logic                    request,
  output logic [PORT_W-1:0]       address,
  input  logic [NPORTS-1:0]       arb_r,
  input  logic [NPORTS*ANS_W-1:0] arb_answer,
  output logic [NPORTS-1:0]       release_pulse,
  output logic                    xbar_valid,
  output logic [DATA_W-1:0]       xbar_data,
  output logic                    xbar_last,
  input  logic                    xbar_ready,
  output logic [PORT_W-1:0]       xbar_sel,
  output logic [7:0]              drop_cnt
);

  state_t              state_reg, state_next;
  logic [PORT_W-1:0]   dest_reg, dest_next;
  logic [PORT_W-1:0]   address_reg, address_next;
  logic [PORT_W-1:0]   sel_reg, sel_next;
  logic                request_reg, request_next;
  logic [NPORTS-1:0]   release_reg, release_next;
  logic [15:0]         timer_reg, timer_next;
  logic [7:0]          drop_reg, drop_next;
  logic                grant;
  logic                timeout_hit;

  assign grant       = is_grant(arb_r, arb_answer, dest_reg, PORT_W'(PORT_ID));
  assign timeout_hit = (timer_reg == 16'(TIMEOUT - 1));

  always_comb begin
    state_next   = state_reg;
    dest_next    = dest_reg;
    address_next = address_reg;
    sel_next     = sel_reg;
    request_next = request_reg;
    release_next = '0;
    timer_next   = timer_reg;
    drop_next    = drop_reg;
    src_ready    = 1'b0;
    xbar_valid   = 1'b0;
    xbar_data    = '0;
    xbar_last    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // Header is only peeked here; it is consumed later by XFER or DROP.
        if (src_valid) begin
          dest_next    = src_data[PORT_W-1:0];
          address_next = src_data[PORT_W-1:0];
          request_next = 1'b1;
          timer_next   = '0;
          state_next   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (grant) begin
          sel_next     = dest_reg;
          request_next = 1'b0;
          state_next   = ST_XFER;
        end else if (timeout_hit) begin
          request_next = 1'b0;
          drop_next    = (drop_reg == 8'hFF) ? drop_reg : drop_reg + 8'd1;
          state_next   = ST_DROP;
        end else begin
          timer_next = timer_reg + 16'd1;
        end
      end
      ST_XFER: begin
        src_ready  = xbar_ready;
        xbar_valid = src_valid;
        xbar_data  = src_data;
        xbar_last  = src_last;
        if (src_valid && xbar_ready && src_last) begin
          release_next = NPORTS'(1) << dest_reg;
          state_next   = ST_REL;
        end
      end
      ST_REL: begin
        state_next = ST_IDLE;
      end
      ST_DROP: begin
        src_ready = 1'b1;
        if (src_valid && src_last) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      dest_reg    <= '0;
      address_reg <= '0;
      sel_reg     <= '0;
      request_reg <= 1'b0;
      release_reg <= '0;
      timer_reg   <= '0;
      drop_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      dest_reg    <= dest_next;
      address_reg <= address_next;
      sel_reg     <= sel_next;
      request_reg <= request_next;
      release_reg <= release_next;
      timer_reg   <= timer_next;
      drop_reg    <= drop_next;
    end
  end

  assign request       = request_reg;
  assign address       = address_reg;
  assign release_pulse = release_reg;
  assign xbar_sel      = sel_reg;
  assign drop_cnt      = drop_reg;

endmodule

// File: tb/tb_xbar_in_requester.sv
// Scoreboard bench for xbar_in_requester: a packet-level model queues the
// expected crossbar words, request lengths and releases; monitors compare.
module tb_xbar_in_requester;

  localparam int PORT_ID = 1;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 4;
  localparam logic [2:0] MY_ANS    = 3'b001;
  localparam logic [2:0] OTHER_ANS = 3'b011;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              src_valid = 1'b0;
  logic [DATA_W-1:0] src_data = '0;
  logic              src_last = 1'b0;
  logic              src_ready;
  logic              request;
  logic [1:0]        address;
  logic [3:0]        arb_r = '0;
  logic [11:0]       arb_answer = 12'h924;
  logic [3:0]        release_pulse;
  logic              xbar_valid;
  logic [DATA_W-1:0] xbar_data;
  logic              xbar_last;
  logic              xbar_ready = 1'b0;
  logic [1:0]        xbar_sel;
  logic [7:0]        drop_cnt;

  xbar_in_requester #(.PORT_ID(PORT_ID), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .src_valid(src_valid), .src_data(src_data), .src_last(src_last), .src_ready(src_ready),
    .request(request), .address(address), .arb_r(arb_r), .arb_answer(arb_answer),
    .release_pulse(release_pulse),
    .xbar_valid(xbar_valid), .xbar_data(xbar_data), .xbar_last(xbar_last),
    .xbar_ready(xbar_ready), .xbar_sel(xbar_sel), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] data; logic last; logic [1:0] sel; } word_t;
  typedef struct { int len; logic [1:0] addr; } req_t;

  word_t      exp_words[$];
  req_t       exp_req[$];
  logic [3:0] exp_rel[$];

  int n_checks = 0;
  int n_pass   = 0;
  int model_drop = 0;

  int plan_dest  = 0;
  int plan_grant = 99;
  bit plan_wrong = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // Arbiter stand-in: noise on every output, a real grant only at the planned cycle.
  initial begin : arbiter
    int idx;
    logic [3:0]  r;
    logic [11:0] a;
    logic [2:0]  f;
    idx = 0;
    forever begin
      @(negedge clk);
      r = 4'($urandom);
      a = 12'($urandom);
      if (request) begin
        if (idx == plan_grant) begin
          r[plan_dest] = 1'b1;
          f = MY_ANS;
        end else if (plan_wrong) begin
          r[plan_dest] = 1'b1;
          f = OTHER_ANS;
        end else begin
          f = a[3*plan_dest +: 3];
          if (f == MY_ANS) f = 3'b100;
        end
        a[3*plan_dest +: 3] = f;
        idx++;
      end else begin
        idx = 0;
      end
      arb_r      = r;
      arb_answer = a;
    end
  end

  initial begin : monitor
    int run;
    word_t w;
    req_t  q;
    logic [3:0] rl;
    run = 0;
    forever begin
      @(negedge clk);
      #3;
      if (xbar_valid && xbar_ready) begin
        chk("xbar_word_expected", 32'(exp_words.size() > 0), 1);
        if (exp_words.size() > 0) begin
          w = exp_words.pop_front();
          chk("xbar_data", 32'(xbar_data), 32'(w.data));
          chk("xbar_last", 32'(xbar_last), 32'(w.last));
          chk("xbar_sel", 32'(xbar_sel), 32'(w.sel));
        end
      end
      if (release_pulse != 4'b0) begin
        chk("release_expected", 32'(exp_rel.size() > 0), 1);
        if (exp_rel.size() > 0) begin
          rl = exp_rel.pop_front();
          chk("release_onehot", 32'(release_pulse), 32'(rl));
        end
      end
      if (request) begin
        run++;
        chk("request_expected", 32'(exp_req.size() > 0), 1);
        if (exp_req.size() > 0) chk("address", 32'(address), 32'(exp_req[0].addr));
      end else if (run > 0) begin
        if (exp_req.size() > 0) begin
          q = exp_req.pop_front();
          chk("request_cycles", 32'(run), 32'(q.len));
        end
        run = 0;
      end
    end
  end

  // dest, word count, grant cycle (>= TIMEOUT: none), wrong-port noise,
  // ready mode (0 random, 1 pattern 1001, 2 always), reset word index (-1 none).
  task automatic run_packet(input int dest, input int nw, input int gc, input bit wrong,
                            input int rmode, input int rst_at, input bit zero_hi);
    logic [7:0] w[$];
    logic pat[4];
    bit granted;
    int idx, pidx, cycles, n_exp;
    bit gap;
    word_t e;
    req_t r;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    w.push_back({zero_hi ? 6'd0 : 6'($urandom), 2'(dest)});
    for (int i = 1; i < nw; i++) w.push_back(8'($urandom));
    granted = (gc < TIMEOUT);
    r.len  = granted ? gc + 1 : TIMEOUT;
    r.addr = 2'(dest);
    exp_req.push_back(r);
    if (granted) begin
      n_exp = (rst_at >= 0) ? rst_at : nw;
      for (int i = 0; i < n_exp; i++) begin
        e.data = w[i];
        e.last = (i == nw - 1);
        e.sel  = 2'(dest);
        exp_words.push_back(e);
      end
      if (rst_at < 0) exp_rel.push_back(4'(1 << dest));
    end else begin
      model_drop = (model_drop >= 255) ? 255 : model_drop + 1;
    end
    plan_dest  = dest;
    plan_grant = gc;
    plan_wrong = wrong;
    idx = 0; pidx = 0; cycles = 0;
    while (idx < nw) begin
      @(negedge clk);
      cycles++;
      if (cycles > 300) begin
        n_checks++;
        $display("FAIL packet_cycle_budget: packet stuck at word %0d of %0d", idx, nw);
        break;
      end
      gap = (idx > 0) && (rmode == 0) && ($urandom_range(0, 3) == 0);
      src_valid = !gap;
      src_data  = w[idx];
      src_last  = (idx == nw - 1);
      if (idx == rst_at) begin
        xbar_ready = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        src_valid = 1'b0;
        src_last = 1'b0;
        #2;
        chk("rst_request", 32'(request), 0);
        chk("rst_address", 32'(address), 0);
        chk("rst_release", 32'(release_pulse), 0);
        chk("rst_xbar_sel", 32'(xbar_sel), 0);
        chk("rst_xbar_valid", 32'(xbar_valid), 0);
        chk("rst_src_ready", 32'(src_ready), 0);
        chk("rst_drop_cnt", 32'(drop_cnt), 0);
        model_drop = 0;
        plan_grant = 99;
        return;
      end
      #1;
      if (rmode == 1 && xbar_valid) begin
        xbar_ready = pat[pidx % 4];
        pidx++;
      end else if (rmode == 2) begin
        xbar_ready = 1'b1;
      end else begin
        xbar_ready = ($urandom_range(0, 3) != 0);
      end
      #1;
      if (src_valid && src_ready) idx++;
    end
    @(negedge clk);
    src_valid = 1'b0;
    src_last  = 1'b0;
    @(negedge clk);
    #2;
    chk("drop_cnt", 32'(drop_cnt), 32'(model_drop));
    plan_grant = 99;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    @(negedge clk);
    src_valid = 1'b1;
    src_data  = 8'h03;
    repeat (3) @(negedge clk);
    #2;
    chk("reset_request", 32'(request), 0);
    chk("reset_address", 32'(address), 0);
    chk("reset_release", 32'(release_pulse), 0);
    chk("reset_xbar_sel", 32'(xbar_sel), 0);
    chk("reset_src_ready", 32'(src_ready), 0);
    chk("reset_xbar_valid", 32'(xbar_valid), 0);
    chk("reset_drop_cnt", 32'(drop_cnt), 0);
    @(negedge clk);
    reset = 1'b1;
    src_valid = 1'b0;
    src_data = '0;

    run_packet(2, 4, 1, 1'b0, 2, -1, 1'b1);   // header 8'h02, grant on 2nd request cycle
    run_packet(2, 3, 2, 1'b1, 0, -1, 1'b0);   // wrong-port answers first
    run_packet(3, 2, 99, 1'b0, 0, -1, 1'b0);  // timeout drop
    run_packet(0, 3, 0, 1'b0, 1, -1, 1'b0);   // ready pattern 1,0,0,1
    run_packet(3, 4, 0, 1'b0, 2, 2, 1'b0);    // reset during word 2
    run_packet(0, 1, TIMEOUT - 1, 1'b0, 0, -1, 1'b0); // grant on timeout edge
    run_packet(1, 3, 1, 1'b1, 0, -1, 1'b0);   // loopback destination

    for (int i = 0; i < 40; i++)
      run_packet($urandom_range(0, 3), $urandom_range(1, 5), $urandom_range(0, 5),
                 1'($urandom), $urandom_range(0, 2), -1, 1'b0);

    for (int i = 0; i < 256; i++)
      run_packet($urandom_range(0, 3), 1, TIMEOUT + $urandom_range(0, 2),
                 1'($urandom), 0, -1, 1'b0);
    chk("drop_cnt_saturated", 32'(drop_cnt), 255);

    repeat (5) @(negedge clk);
    chk("words_outstanding", 32'(exp_words.size()), 0);
    chk("requests_outstanding", 32'(exp_req.size()), 0);
    chk("releases_outstanding", 32'(exp_rel.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/xbar_in_requester.md
# xbar_in_requester

Input-side companion of the 4x4 crossbar output round-robin arbiters, one instance per input port. Takes a packet stream from the input buffer, reads the destination from the header word, and asserts its request and 2-bit address toward the output arbiters. It then waits for the matching grant, streams the packet through the crossbar, and pulses a release to the granted output so that output's state machine returns to idle. If no grant arrives within a bounded time, the requester drops the packet.

## Interface
- PORT_ID, 0: index of this input port (0..3); the value this block matches in the arbiter answer.
- DATA_W, 8: data word width; header destination is bits [1:0].
- TIMEOUT, 255: maximum cycles spent requesting before drop; range 1..65535.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-low.
- src_valid  in  1  input buffer word valid.
- src_data  in  DATA_W  input buffer word; first word of packet is header.
- src_last  in  1  marks final word of packet.
- src_ready  out  1  word accepted when src_valid && src_ready.
- request  out  1  drives requests[PORT_ID] of all output arbiters.
- address  out  2  drives address[2*PORT_ID+1:2*PORT_ID]; the destination output.
- arb_r  in  4  ArbR of outputs 0..3.
- arb_answer  in  12  arbiter_answer of output k at [3k+2:3k].
- release  out  4  one-hot, one-cycle pulse to output k's state machine.
- xbar_valid  out  1  crossbar word valid.
- xbar_data  out  DATA_W  crossbar word.
- xbar_last  out  1  crossbar last word.
- xbar_ready  in  1  crossbar/output accepts word.
- xbar_sel  out  2  output currently owned (valid in XFER).
- drop_cnt  out  8  saturating count of packets dropped on timeout.

## Operation
- States: IDLE, REQ, XFER, REL, DROP.
- Reset (reset==0 at clk edge) is checked before any other condition. It forces:
  - state to IDLE.
  - request, address, release, xbar_sel, dest register, timer and drop_cnt to 0.
  - src_ready and xbar_valid to 0, because both are combinational from state.
- Reset mid-packet abandons the packet without a release; the output side has its own reset.
- IDLE: src_ready=0. If src_valid, latch dest=src_data[1:0], clear the timer and go to REQ. The header is not consumed.
- REQ: request=1, address=dest. Grant means arb_r[dest]==1 && arb_answer[3*dest+:3]=={1'b0,PORT_ID[1:0]}.
  - On grant: go to XFER, xbar_sel<=dest, request<=0.
  - Otherwise timer increments. When timer reaches TIMEOUT-1 without grant: request<=0, go to DROP.
  - Grant in the same cycle as timeout: grant wins.
  - Grants for other ports, or arb_r set with a different answer, are ignored.
- XFER: pass-through. xbar_valid=src_valid, xbar_data=src_data, xbar_last=src_last, src_ready=xbar_ready.
  - On an accepted word with src_last: go to REL.
  - A one-word packet (header with src_last) goes directly to REL.
- REL: release[dest]=1 for exactly one cycle, then IDLE. A new request cannot assert earlier than the cycle after REL.
- DROP: src_ready=1, xbar_valid=0.
  - Words are discarded until an accepted src_last, then go to IDLE.
  - drop_cnt increments once per dropped packet and saturates at 255.
- dest==PORT_ID (loopback) is legal and treated identically.

## Timing
- src_valid in IDLE at edge N leads to request=1 and address valid from edge N+1. request, address, release and xbar_sel are registered.
- Grant sampled at edge M leads to XFER from M+1, with request low from M+1. The first header word can transfer in cycle M+1.
- xbar_* and src_ready are combinational from state and the src/xbar signals; there is no added data latency.
- Last word accepted at edge L: release pulse in cycle L+1, IDLE at L+2.
- Minimum packet-to-packet spacing is 3 cycles of overhead: IDLE, REQ, REL.
- Timeout: request is high for exactly TIMEOUT cycles, then DROP.

## Structure
- Shared package xbar_pkg holds:
  - state encoding constants.
  - NPORTS=4 and port-index width 2.
  - arbiter answer width 3 and the IDLE answer value 3'b100.
- Keep everything in one module; no sub-module is needed. The grant decode is a small function in the package.

## Test plan
- PORT_ID=1, header 8'h02 plus 3 words, arb_r[2]=1 with answer 3'b001 two cycles after request -> request high 2 cycles, address=2, 4 words out with xbar_sel=2, release=4'b0100 for one cycle.
- Grant on the wrong port: arb_r[2]=1, answer 3'b011, PORT_ID=1 -> request stays high, no transfer; a correct grant later -> normal transfer.
- TIMEOUT=4, no grant, 2-word packet -> request high exactly 4 cycles, both words consumed with xbar_valid=0, drop_cnt=1, no release.
- xbar_ready toggling 1,0,0,1 during a 3-word packet -> each word held until accepted, xbar_last only on word 3, release once.
- reset=0 asserted during XFER word 2 -> next cycle all outputs 0, state IDLE, no release; the next packet requests normally.
- One-word packet (header with src_last, dest=0), grant at the same edge as timeout -> transfer happens, release=4'b0001, drop_cnt unchanged.
